// File: rtl/ec_sec2_pkg.sv
// Shared definitions for the SEC 2 binary-field curve datapath.
//   - Field degrees and reduction polynomials (x^M term omitted) for
//     sect163r2, sect233r1 and sect283r1.
//   - FSM state type used by the digit-serial multiplier.
package ec_sec2_pkg;

    // sect163r2: f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam int unsigned Sect163r2M = 163;
    localparam logic [162:0] Sect163r2P =
        (163'd1 << 7) | (163'd1 << 6) | (163'd1 << 3) | 163'd1;

    // sect233r1: f(x) = x^233 + x^74 + 1
    localparam int unsigned Sect233r1M = 233;
    localparam logic [232:0] Sect233r1P = (233'd1 << 74) | 233'd1;

    // sect283r1: f(x) = x^283 + x^12 + x^7 + x^5 + 1
    localparam int unsigned Sect283r1M = 283;
    localparam logic [282:0] Sect283r1P =
        (283'd1 << 12) | (283'd1 << 7) | (283'd1 << 5) | 283'd1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } mul_state_e;

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit iteration of the MSB-first digit-serial GF(2^m) multiplier.
//   acc_next = (acc * x^D mod f) xor (a * b_digit mod f)
// Ports:
//   acc      in  M  current reduced accumulator
//   a        in  M  multiplicand (reduced)
//   b_digit  in  D  current multiplier digit, bit D-1 is most significant
//   acc_next out M  updated reduced accumulator
// Purely combinational.
module gf2m_digit_step
    import ec_sec2_pkg::*;
#(
    parameter int unsigned    M = Sect233r1M,
    parameter int unsigned    D = 4,
    parameter logic [M-1:0]   P = M'(Sect233r1P)
) (
    input  logic [M-1:0] acc,
    input  logic [M-1:0] a,
    input  logic [D-1:0] b_digit,
    output logic [M-1:0] acc_next
);

    // Horner over the digit bits: each step multiplies by x (folding the
    // overflow bit back through P) and adds a where the digit bit is set.
    // After D steps this equals acc*x^D + a*b_digit, fully reduced.
    always_comb begin
        acc_next = acc;
        for (int i = int'(D) - 1; i >= 0; i--) begin
            acc_next = {acc_next[M-2:0], 1'b0}
                     ^ (acc_next[M-1] ? P : '0)
                     ^ (b_digit[i] ? a : '0);
        end
    end

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^m) multiplier, polynomial basis, MSB digit first.
// Computes c = a*b mod f(x) in N = ceil(M/D) cycles after start.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  synchronous clear (priority over start)
//   start  in  1  request; a and b sampled with it while idle
//   a, b   in  M  operands
//   busy   out 1  multiplication in progress
//   done   out 1  one-cycle pulse when c is updated
//   c      out M  last product, held until next completion or clear
module gf2m_digit_mul
    import ec_sec2_pkg::*;
#(
    parameter int unsigned    M = Sect233r1M,
    parameter int unsigned    D = 4,
    parameter logic [M-1:0]   P = M'(Sect233r1P)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] c
);

    localparam int unsigned N  = (M + D - 1) / D;
    localparam int unsigned NW = N * D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    mul_state_e    state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [NW-1:0] b_q, b_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [M-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [D-1:0]  b_digit;
    logic [M-1:0]  step_out;

    // b is zero-extended to N*D bits, so the top digit may carry padding zeros.
    assign b_digit = b_q[NW-1 -: D];

    gf2m_digit_step #(
        .M (M),
        .D (D),
        .P (P)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .b_digit  (b_digit),
        .acc_next (step_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (cnt_q == '0) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StRun);
    end

    // Datapath next-state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
            c_d   = '0;
            cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Start is only honoured here, so a request while busy
                    // never disturbs the operands in flight.
                    if (start) begin
                        a_d   = a;
                        b_d   = NW'(b);
                        acc_d = '0;
                        cnt_d = CntLast;
                    end
                end
                StRun: begin
                    acc_d = step_out;
                    b_d   = b_q << D;
                    if (cnt_q == '0) begin
                        c_d    = step_out;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign c    = c_q;

endmodule
